// File: rtl/grid_mem_pkg.sv
// -----------------------------------------------------------------------------
// grid_mem_pkg
// Shared definitions for the grid memory block:
//   STATE_W        - width of the controller state register
//   grid_state_e   - controller states (IDLE, CLEAR, DONE)
//   cell_index()   - row-major flattening of an (x, y) cell coordinate
// -----------------------------------------------------------------------------
package grid_mem_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } grid_state_e;

  // Row-major flat index: y selects the row, x the column within it.
  function automatic int cell_index(input int x, input int y, input int width);
    return (y * width) + x;
  endfunction

endpackage

// File: rtl/grid_memory_if.sv
// -----------------------------------------------------------------------------
// grid_memory_if
// Request/response bundle of the grid memory.
//   wr, rd, addr_x, addr_y, data_in, clr  : requests from the user
//   data_out, rd_valid, busy, clr_done    : responses from the memory
// master modport = requester side, slave modport = memory side.
// -----------------------------------------------------------------------------
interface grid_memory_if #(
  parameter int ADDR_W = 4,
  parameter int ADDR_H = 4,
  parameter int DATA_W = 1
);

  logic              wr;
  logic              rd;
  logic [ADDR_W-1:0] addr_x;
  logic [ADDR_H-1:0] addr_y;
  logic [DATA_W-1:0] data_in;
  logic              clr;
  logic [DATA_W-1:0] data_out;
  logic              rd_valid;
  logic              busy;
  logic              clr_done;

  modport master (
    output wr, rd, addr_x, addr_y, data_in, clr,
    input  data_out, rd_valid, busy, clr_done
  );

  modport slave (
    input  wr, rd, addr_x, addr_y, data_in, clr,
    output data_out, rd_valid, busy, clr_done
  );

endinterface

// File: rtl/grid_sweep.sv
// -----------------------------------------------------------------------------
// grid_sweep
// Nested x/y counter walking every cell in row-major order.
//   clk, rst : clock, asynchronous active-high reset
//   init     : force both counters to 0
//   en       : advance one cell (x fastest, wraps to (0,0) after the last)
//   x, y     : current cell coordinate
//   last     : current cell is (WIDTH-1, HEIGHT-1)
// -----------------------------------------------------------------------------
module grid_sweep #(
  parameter int WIDTH  = 16,
  parameter int HEIGHT = 16,
  parameter int ADDR_W = 4,
  parameter int ADDR_H = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init,
  input  logic              en,
  output logic [ADDR_W-1:0] x,
  output logic [ADDR_H-1:0] y,
  output logic              last
);

  logic [ADDR_W-1:0] x_r;
  logic [ADDR_H-1:0] y_r;
  logic              x_end_s;
  logic              y_end_s;

  assign x_end_s = (x_r == ADDR_W'(WIDTH - 1));
  assign y_end_s = (y_r == ADDR_H'(HEIGHT - 1));

  // Row-major cell counter: x wraps into a y increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_r <= '0;
      y_r <= '0;
    end else if (init) begin
      x_r <= '0;
      y_r <= '0;
    end else if (en) begin
      if (x_end_s) begin
        x_r <= '0;
        if (y_end_s) begin
          y_r <= '0;
        end else begin
          y_r <= y_r + ADDR_H'(1);
        end
      end else begin
        x_r <= x_r + ADDR_W'(1);
      end
    end
  end

  assign x    = x_r;
  assign y    = y_r;
  assign last = x_end_s && y_end_s;

endmodule

// File: rtl/grid_memory.sv
// -----------------------------------------------------------------------------
// grid_memory
// WIDTH x HEIGHT grid of DATA_W-bit cells with single-cycle write, registered
// read (one cycle latency) and a bulk clear that sweeps one cell per cycle.
//   clk, rst  : clock, asynchronous active-high reset (cell contents kept)
//   bus.wr    : write data_in to (addr_x, addr_y)
//   bus.rd    : read (addr_x, addr_y); data_out/rd_valid next cycle
//   bus.clr   : start bulk clear to CLR_VAL (wins over wr/rd)
//   bus.busy  : clear in progress (CLEAR and DONE)
//   bus.clr_done : one-cycle pulse while in DONE
// Out-of-range addresses: writes are dropped, reads return 0 with rd_valid.
// -----------------------------------------------------------------------------
module grid_memory
  import grid_mem_pkg::*;
#(
  parameter int                WIDTH   = 16,
  parameter int                HEIGHT  = 16,
  parameter int                ADDR_W  = 4,
  parameter int                ADDR_H  = 4,
  parameter int                DATA_W  = 1,
  parameter logic [DATA_W-1:0] CLR_VAL = '0
) (
  input logic            clk,
  input logic            rst,
  grid_memory_if.slave   bus
);

  localparam int DEPTH = WIDTH * HEIGHT;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem_r [DEPTH];

  grid_state_e       state_r;
  logic [DATA_W-1:0] data_out_r;
  logic              rd_valid_r;
  logic              busy_r;
  logic              clr_done_r;

  logic              in_range_s;
  logic [IDX_W-1:0]  idx_s;
  logic [IDX_W-1:0]  sweep_idx_s;
  logic              sweep_init_s;
  logic              sweep_en_s;
  logic              sweep_last_s;
  logic [ADDR_W-1:0] sweep_x_s;
  logic [ADDR_H-1:0] sweep_y_s;
  logic              wr_ok_s;

  assign in_range_s = (int'(bus.addr_x) < WIDTH) && (int'(bus.addr_y) < HEIGHT);
  assign idx_s      = IDX_W'(cell_index(int'(bus.addr_x), int'(bus.addr_y), WIDTH));
  assign sweep_idx_s = IDX_W'(cell_index(int'(sweep_x_s), int'(sweep_y_s), WIDTH));

  assign sweep_init_s = (state_r == IDLE) && bus.clr;
  assign sweep_en_s   = (state_r == CLEAR);
  // clr in the same cycle drops the user write.
  assign wr_ok_s      = (state_r == IDLE) && bus.wr && !bus.clr && in_range_s;

  grid_sweep #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT),
    .ADDR_W (ADDR_W),
    .ADDR_H (ADDR_H)
  ) u_sweep (
    .clk  (clk),
    .rst  (rst),
    .init (sweep_init_s),
    .en   (sweep_en_s),
    .x    (sweep_x_s),
    .y    (sweep_y_s),
    .last (sweep_last_s)
  );

  // Cell storage: not reset, so an aborted clear leaves untouched cells intact.
  always_ff @(posedge clk) begin
    if (!rst && (state_r == CLEAR)) begin
      mem_r[sweep_idx_s] <= CLR_VAL;
    end else if (!rst && wr_ok_s) begin
      mem_r[idx_s] <= bus.data_in;
    end
  end

  // Controller FSM with registered read data and status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      data_out_r <= '0;
      rd_valid_r <= 1'b0;
      busy_r     <= 1'b0;
      clr_done_r <= 1'b0;
    end else begin
      rd_valid_r <= 1'b0;
      clr_done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.clr) begin
            state_r <= CLEAR;
            busy_r  <= 1'b1;
          end else if (bus.rd) begin
            rd_valid_r <= 1'b1;
            // Memory read here sees pre-write data for a same-edge write.
            data_out_r <= in_range_s ? mem_r[idx_s] : '0;
          end
        end
        CLEAR: begin
          if (sweep_last_s) begin
            state_r    <= DONE;
            clr_done_r <= 1'b1;
          end
        end
        DONE: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.data_out = data_out_r;
  assign bus.rd_valid = rd_valid_r;
  assign bus.busy     = busy_r;
  assign bus.clr_done = clr_done_r;

endmodule

// File: tb/tb_grid_memory.sv
// -----------------------------------------------------------------------------
// tb_grid_memory
// Self-checking bench for grid_memory at WIDTH=4, HEIGHT=4, DATA_W=8,
// ADDR_W=ADDR_H=3 (so out-of-range coordinates are expressible).
// Expected read data is queued when a read is issued and compared when
// rd_valid is observed.
// -----------------------------------------------------------------------------
module tb_grid_memory;

  logic clk;
  logic rst;

  int tests_run;
  int tests_failed;

  logic [7:0] exp_q[$];

  grid_memory_if #(.ADDR_W(3), .ADDR_H(3), .DATA_W(8)) bus ();

  grid_memory #(
    .WIDTH   (4),
    .HEIGHT  (4),
    .ADDR_W  (3),
    .ADDR_H  (3),
    .DATA_W  (8),
    .CLR_VAL (8'h00)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock, sample #1 after the edge and retire any read result.
  task automatic step();
    logic [7:0] exp;
    @(posedge clk);
    #1;
    if (bus.rd_valid === 1'b1) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL unexpected_rd_valid: got rd_valid=1 data=%h, required no read pending", bus.data_out);
      end else begin
        exp = exp_q.pop_front();
        if (bus.data_out !== exp) begin
          tests_failed++;
          $display("FAIL rd_data: got %h, required %h", bus.data_out, exp);
        end
      end
    end
  endtask

  task automatic do_write(input logic [2:0] x, input logic [2:0] y, input logic [7:0] d);
    bus.wr = 1'b1; bus.addr_x = x; bus.addr_y = y; bus.data_in = d;
    step();
    bus.wr = 1'b0;
  endtask

  // Single read: result must arrive exactly one cycle later, then rd_valid drops
  // while data_out holds.
  task automatic do_read(input logic [2:0] x, input logic [2:0] y, input logic [7:0] exp);
    bus.rd = 1'b1; bus.addr_x = x; bus.addr_y = y;
    exp_q.push_back(exp);
    step();
    bus.rd = 1'b0;
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL rd_latency: got %0d reads still pending, required 0", exp_q.size());
      exp_q.delete();
    end
    step();
    tests_run++;
    if (bus.rd_valid !== 1'b0 || bus.data_out !== exp) begin
      tests_failed++;
      $display("FAIL rd_hold: got rd_valid=%b data=%h, required rd_valid=0 data=%h",
               bus.rd_valid, bus.data_out, exp);
    end
  endtask

  task automatic fill_all(input logic [7:0] d);
    for (int i = 0; i < 16; i++) do_write(3'(i % 4), 3'(i / 4), d);
  endtask

  // Run a started clear to completion, counting busy cycles and done pulses.
  task automatic watch_clear(input string tag);
    int busy_cnt;
    int done_cnt;
    busy_cnt = 0;
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.busy === 1'b1) busy_cnt++;
      if (bus.clr_done === 1'b1) done_cnt++;
      if (bus.busy !== 1'b1) break;
      step();
    end
    tests_run++;
    if (busy_cnt != 17) begin
      tests_failed++;
      $display("FAIL %s_busy_cycles: got %0d, required 17", tag, busy_cnt);
    end
    tests_run++;
    if (done_cnt != 1) begin
      tests_failed++;
      $display("FAIL %s_clr_done_pulses: got %0d, required 1", tag, done_cnt);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #23;
    tests_run++;
    if (bus.data_out !== 8'h00 || bus.rd_valid !== 1'b0 || bus.busy !== 1'b0 || bus.clr_done !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got data=%h rd_valid=%b busy=%b clr_done=%b, required all 0",
               bus.data_out, bus.rd_valid, bus.busy, bus.clr_done);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_write_read();
    do_write(3'd2, 3'd3, 8'hA5);
    do_read(3'd2, 3'd3, 8'hA5);
    do_write(3'd0, 3'd0, 8'h3C);
    do_read(3'd0, 3'd0, 8'h3C);
    do_read(3'd2, 3'd3, 8'hA5);
  endtask

  task automatic test_same_cell();
    do_write(3'd1, 3'd1, 8'h11);
    bus.wr = 1'b1; bus.rd = 1'b1; bus.addr_x = 3'd1; bus.addr_y = 3'd1; bus.data_in = 8'h22;
    exp_q.push_back(8'h11);
    step();
    bus.wr = 1'b0; bus.rd = 1'b0;
    do_read(3'd1, 3'd1, 8'h22);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) do_write(3'(i), 3'd2, 8'(8'h40 + i));
    bus.rd = 1'b1;
    for (int i = 3; i >= 0; i--) begin
      bus.addr_x = 3'(i); bus.addr_y = 3'd2;
      exp_q.push_back(8'(8'h40 + i));
      step();
    end
    bus.rd = 1'b0;
    step();
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL b2b_pending: got %0d reads outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_clear();
    fill_all(8'hFF);
    bus.clr = 1'b1;
    step();
    bus.clr = 1'b0;
    // Requests during the sweep must be ignored.
    bus.rd = 1'b1; bus.wr = 1'b1; bus.addr_x = 3'd0; bus.addr_y = 3'd0; bus.data_in = 8'h77;
    watch_clear("clear");
    bus.rd = 1'b0; bus.wr = 1'b0;
    for (int i = 0; i < 16; i++) do_read(3'(i % 4), 3'(i / 4), 8'h00);
  endtask

  task automatic test_reset_during_clear();
    fill_all(8'hFF);
    do_read(3'd3, 3'd3, 8'hFF);
    bus.clr = 1'b1;
    step();
    bus.clr = 1'b0;
    for (int i = 0; i < 5; i++) step();
    rst = 1'b1;
    #1;
    tests_run++;
    if (bus.data_out !== 8'h00 || bus.rd_valid !== 1'b0 || bus.busy !== 1'b0 || bus.clr_done !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_outputs: got data=%h rd_valid=%b busy=%b clr_done=%b, required all 0",
               bus.data_out, bus.rd_valid, bus.busy, bus.clr_done);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    do_read(3'd0, 3'd0, 8'h00);
    do_read(3'd3, 3'd0, 8'h00);
    do_read(3'd0, 3'd1, 8'h00);
    do_read(3'd1, 3'd1, 8'hFF);
    do_read(3'd3, 3'd3, 8'hFF);
  endtask

  task automatic test_out_of_range();
    fill_all(8'h3C);
    do_write(3'd5, 3'd0, 8'h5A);
    do_write(3'd1, 3'd6, 8'h5A);
    do_read(3'd5, 3'd0, 8'h00);
    do_read(3'd0, 3'd6, 8'h00);
    for (int i = 0; i < 16; i++) do_read(3'(i % 4), 3'(i / 4), 8'h3C);
  endtask

  task automatic test_wr_clr_priority();
    fill_all(8'hC3);
    bus.wr = 1'b1; bus.rd = 1'b1; bus.clr = 1'b1;
    bus.addr_x = 3'd2; bus.addr_y = 3'd2; bus.data_in = 8'h99;
    step();
    bus.wr = 1'b0; bus.rd = 1'b0; bus.clr = 1'b0;
    watch_clear("wrclr");
    do_read(3'd2, 3'd2, 8'h00);
    do_read(3'd3, 3'd3, 8'h00);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    bus.wr = 1'b0; bus.rd = 1'b0; bus.clr = 1'b0;
    bus.addr_x = 3'd0; bus.addr_y = 3'd0; bus.data_in = 8'h00;
    test_reset();
    test_write_read();
    test_same_cell();
    test_back_to_back();
    test_clear();
    test_reset_during_clear();
    test_out_of_range();
    test_wr_clr_priority();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
